// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: shares one RAM port between instruction
// fetches and data reads/writes. Data requests win over instruction reads,
// writes win over reads. Each access is followed by one IDLE cycle so a
// still-asserted request is never granted twice. A watchdog abandons any
// access for which the RAM never raises ram_ready.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        n_rst,
    // instruction requester
    input  logic        iren,
    input  logic [31:0] iaddr,
    output logic        ihit,
    output logic [31:0] iload,
    // data requester
    input  logic        dren,
    input  logic        dwen,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dhit,
    output logic [31:0] dload,
    // shared RAM port
    output logic        ram_ren,
    output logic        ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_store,
    input  logic [31:0] ram_load,
    input  logic        ram_ready,
    // watchdog abort pulse
    output logic        timeout
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    // Last wait-cycle index; reaching it without ram_ready aborts the access.
    localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IRD  = 2'd1,
        ST_DRD  = 2'd2,
        ST_DWR  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [WCNT_W-1:0]   wcnt_r;
    logic [WCNT_W-1:0]   wcnt_nxt_s;
    logic [31:0]         addr_r;
    logic [31:0]         addr_nxt_s;
    logic [31:0]         store_r;
    logic [31:0]         store_nxt_s;
    logic                limit_s;
    logic                timeout_s;

    assign limit_s = (wcnt_r == WCNT_LIMIT);

    // State, watchdog counter and address/data latches.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= ST_IDLE;
            wcnt_r  <= {WCNT_W{1'b0}};
            addr_r  <= 32'h0000_0000;
            store_r <= 32'h0000_0000;
        end else begin
            state_r <= state_nxt_s;
            wcnt_r  <= wcnt_nxt_s;
            addr_r  <= addr_nxt_s;
            store_r <= store_nxt_s;
        end
    end

    // Grant by priority from IDLE; finish or abort the running access.
    always_comb begin
        state_nxt_s = state_r;
        wcnt_nxt_s  = wcnt_r;
        addr_nxt_s  = addr_r;
        store_nxt_s = store_r;
        timeout_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Counter is held at zero so every access starts from a fresh count.
                wcnt_nxt_s = {WCNT_W{1'b0}};
                if (dwen) begin
                    state_nxt_s = ST_DWR;
                    addr_nxt_s  = daddr;
                    store_nxt_s = dstore;
                end else if (dren) begin
                    state_nxt_s = ST_DRD;
                    addr_nxt_s  = daddr;
                end else if (iren) begin
                    state_nxt_s = ST_IRD;
                    addr_nxt_s  = iaddr;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_IRD, ST_DRD, ST_DWR: begin
                // ram_ready on the limit cycle still counts as a normal completion.
                if (ram_ready) begin
                    state_nxt_s = ST_IDLE;
                    wcnt_nxt_s  = {WCNT_W{1'b0}};
                end else if (limit_s) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                    wcnt_nxt_s  = {WCNT_W{1'b0}};
                end else begin
                    wcnt_nxt_s  = wcnt_r + WCNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                wcnt_nxt_s  = {WCNT_W{1'b0}};
            end
        endcase
    end

    // Output decode: enables follow the state register, hits follow ram_ready.
    always_comb begin
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ihit      = 1'b0;
        iload     = 32'h0000_0000;
        dhit      = 1'b0;
        dload     = 32'h0000_0000;
        ram_addr  = addr_r;
        ram_store = store_r;
        timeout   = timeout_s;
        case (state_r)
            ST_IDLE: begin
                ram_ren = 1'b0;
                ram_wen = 1'b0;
            end
            ST_IRD: begin
                ram_ren = 1'b1;
                if (ram_ready) begin
                    ihit  = 1'b1;
                    iload = ram_load;
                end else begin
                    ihit  = 1'b0;
                end
            end
            ST_DRD: begin
                ram_ren = 1'b1;
                if (ram_ready) begin
                    dhit  = 1'b1;
                    dload = ram_load;
                end else begin
                    dhit  = 1'b0;
                end
            end
            ST_DWR: begin
                ram_wen = 1'b1;
                // A write completion reports no load data.
                if (ram_ready) begin
                    dhit = 1'b1;
                end else begin
                    dhit = 1'b0;
                end
            end
            default: begin
                ram_ren = 1'b0;
                ram_wen = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter. The requester side pushes
// the expected outcome of every transaction (data before instruction,
// write before read, timeout when the RAM is slower than TIMEOUT cycles);
// an independent monitor pops an entry whenever the DUT reports a hit or a
// timeout and compares kind, data and latency. A small RAM model answers
// after a chosen number of enabled cycles.
module tb_mem_arbiter;

    localparam int TO = 8;

    logic        clk;
    logic        n_rst;
    logic        iren, dren, dwen;
    logic [31:0] iaddr, daddr, dstore;
    logic        ihit, dhit, timeout;
    logic [31:0] iload, dload;
    logic        ram_ren, ram_wen, ram_ready;
    logic [31:0] ram_addr, ram_store, ram_load;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .n_rst(n_rst),
        .iren(iren), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore),
        .dhit(dhit), .dload(dload),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready),
        .timeout(timeout)
    );

    // kind: 0 instruction read, 1 data read, 2 data write
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        int          delay;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          ram_delay = 1;
    int          write_count = 0;
    logic [31:0] ram_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        check(name, {31'd0, act}, {31'd0, req});
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // RAM model: ready in the ram_delay-th enabled cycle, random ready in idle.
    initial begin
        int acc;
        acc = 0;
        ram_ready = 1'b0;
        ram_load = 32'h0;
        forever begin
            @(negedge clk);
            if (n_rst && (ram_ren || ram_wen)) begin
                acc++;
                ram_ready = (acc == ram_delay);
                if (ram_ready && ram_ren)
                    ram_load = ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : init_word(ram_addr);
                else
                    ram_load = $urandom;
                if (ram_ready && ram_wen) begin
                    ram_mem[ram_addr] = ram_store;
                    write_count++;
                end
            end else begin
                acc = 0;
                ram_ready = 1'($urandom_range(0, 1));
                ram_load = $urandom;
            end
        end
    end

    // Monitor: per-cycle port checks, pop-and-compare on every hit/timeout.
    initial begin
        int   cyc;
        int   lat;
        bit   prev_done;
        bit   hit_ok;
        exp_t h;
        cyc = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!n_rst) begin
                cyc = 0;
                prev_done = 1'b0;
                continue;
            end
            if (ram_ren || ram_wen) begin
                if (prev_done) check("idle_gap", {30'd0, ram_ren, ram_wen}, 32'd0);
                cyc++;
                if (exp_q.size() == 0) begin
                    check("unexpected_access", {30'd0, ram_ren, ram_wen}, 32'd0);
                    prev_done = 1'b0;
                end else begin
                    h = exp_q[0];
                    check("ram_addr", ram_addr, h.addr);
                    chk1("ram_wen", ram_wen, h.kind == 2);
                    chk1("ram_ren", ram_ren, h.kind != 2);
                    if (h.kind == 2) check("ram_store", ram_store, h.data);
                    if (ihit || dhit || timeout) begin
                        void'(exp_q.pop_front());
                        hit_ok = (h.delay <= TO);
                        lat = hit_ok ? h.delay : TO;
                        chk1("ihit", ihit, hit_ok && h.kind == 0);
                        chk1("dhit", dhit, hit_ok && h.kind != 0);
                        chk1("timeout", timeout, !hit_ok);
                        check("latency", 32'(cyc), 32'(lat));
                        check("iload", iload, (hit_ok && h.kind == 0) ? h.data : 32'h0);
                        check("dload", dload, (hit_ok && h.kind == 1) ? h.data : 32'h0);
                        cyc = 0;
                        prev_done = 1'b1;
                    end else begin
                        check("iload_quiet", iload, 32'h0);
                        check("dload_quiet", dload, 32'h0);
                        prev_done = 1'b0;
                    end
                end
            end else begin
                check("idle_pulses", {29'd0, ihit, dhit, timeout}, 32'd0);
                check("idle_loads", iload | dload, 32'h0);
                cyc = 0;
                prev_done = 1'b0;
            end
        end
    end

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        ram_mem[a] = d;
        ref_mem[a] = d;
    endtask

    // One requester episode: pushes expectations, drives levels, drops each
    // request after its completion is observed.
    task automatic run(input bit do_i, input bit do_dr, input bit do_dw,
                       input logic [31:0] ia, input logic [31:0] da,
                       input logic [31:0] ds, input int dly, input bit scramble);
        exp_t e;
        bit   ev_i, ev_d, ev_t;
        ram_delay = dly;
        if (do_dr || do_dw) begin
            e.kind  = do_dw ? 2 : 1;
            e.addr  = da;
            e.data  = do_dw ? ds : ref_read(da);
            e.delay = dly;
            exp_q.push_back(e);
            if (do_dw && dly <= TO) ref_mem[da] = ds;
        end
        if (do_i) begin
            e.kind  = 0;
            e.addr  = ia;
            e.data  = ref_read(ia);
            e.delay = dly;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        iren = do_i; dren = do_dr; dwen = do_dw;
        iaddr = ia; daddr = da; dstore = ds;
        for (int c = 0; c < 60 && (iren || dren || dwen); c++) begin
            @(negedge clk);
            #2;
            ev_i = ihit; ev_d = dhit; ev_t = timeout;
            @(posedge clk);
            #1;
            if (ev_d || (ev_t && (dren || dwen))) begin
                dren = 1'b0;
                dwen = 1'b0;
            end else if (ev_i || (ev_t && iren)) begin
                iren = 1'b0;
            end else if (scramble) begin
                iaddr = $urandom; daddr = $urandom; dstore = $urandom;
            end
        end
        if (iren || dren || dwen) begin
            check("req_budget", {29'd0, iren, dren, dwen}, 32'd0);
            iren = 1'b0; dren = 1'b0; dwen = 1'b0;
            exp_q.delete();
        end
    endtask

    // Reset asserted while a data read is waiting on the RAM.
    task automatic reset_mid(input logic [31:0] da);
        exp_t e;
        ram_delay = 6;
        e.kind = 1; e.addr = da; e.data = ref_read(da); e.delay = 6;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        dren = 1'b1; daddr = da;
        repeat (3) @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        chk1("rst_ihit", ihit, 1'b0);
        chk1("rst_dhit", dhit, 1'b0);
        chk1("rst_timeout", timeout, 1'b0);
        chk1("rst_ram_ren", ram_ren, 1'b0);
        chk1("rst_ram_wen", ram_wen, 1'b0);
        check("rst_iload", iload, 32'h0);
        check("rst_dload", dload, 32'h0);
        check("rst_ram_addr", ram_addr, 32'h0);
        check("rst_ram_store", ram_store, 32'h0);
        exp_q.delete();
        dren = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        n_rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_idle", {30'd0, ram_ren, ram_wen}, 32'd0);
    endtask

    initial begin
        int          wc, sel, dly, exp_w;
        bit          di, ddr, ddw;
        logic [31:0] ia, da, ds;
        n_rst = 1'b0;
        iren = 1'b0; dren = 1'b0; dwen = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk1("reset_ihit", ihit, 1'b0);
        chk1("reset_dhit", dhit, 1'b0);
        chk1("reset_timeout", timeout, 1'b0);
        chk1("reset_ram_ren", ram_ren, 1'b0);
        chk1("reset_ram_wen", ram_wen, 1'b0);
        check("reset_iload", iload, 32'h0);
        check("reset_dload", dload, 32'h0);
        check("reset_ram_addr", ram_addr, 32'h0);
        check("reset_ram_store", ram_store, 32'h0);
        #2;
        n_rst = 1'b1;
        repeat (3) @(posedge clk);

        // Directed cases.
        poke(32'h40, 32'h8C22_0004);
        run(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 3, 1'b0);
        run(1'b1, 1'b1, 1'b0, 32'h44, 32'h100, 32'h0, 1, 1'b0);
        wc = write_count;
        run(1'b0, 1'b1, 1'b1, 32'h0, 32'h200, 32'hDEAD_BEEF, 1, 1'b0);
        repeat (3) @(posedge clk);
        check("single_write", 32'(write_count - wc), 32'd1);
        run(1'b1, 1'b0, 1'b0, 32'h48, 32'h0, 32'h0, 4, 1'b1);
        run(1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h0, 2, 1'b0);
        run(1'b1, 1'b0, 1'b0, 32'h50, 32'h0, 32'h0, TO + 1, 1'b0);
        run(1'b0, 1'b1, 1'b0, 32'h0, 32'h54, 32'h0, TO, 1'b0);
        wc = write_count;
        run(1'b0, 1'b0, 1'b1, 32'h0, 32'h200, 32'h1234_5678, TO + 1, 1'b0);
        repeat (3) @(posedge clk);
        check("aborted_write", 32'(write_count - wc), 32'd0);
        run(1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h0, 1, 1'b0);
        reset_mid(32'h300);

        // Randomised traffic over a small address window so reads hit writes.
        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 5);
            di  = (sel == 0) || (sel == 3) || (sel == 4);
            ddr = (sel == 1) || (sel == 3) || (sel == 5);
            ddw = (sel == 2) || (sel == 4) || (sel == 5);
            ia  = 32'h1000 | (32'($urandom_range(0, 7)) << 2);
            da  = 32'h1000 | (32'($urandom_range(0, 7)) << 2);
            ds  = $urandom;
            case ($urandom_range(0, 3))
                0:       dly = $urandom_range(1, 3);
                1:       dly = TO - 1 + $urandom_range(0, 2);
                default: dly = $urandom_range(1, TO + 3);
            endcase
            exp_w = (ddw && dly <= TO) ? 1 : 0;
            wc = write_count;
            run(di, ddr, ddw, ia, da, ds, dly, !(di && (ddr || ddw)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            check("write_count", 32'(write_count - wc), 32'(exp_w));
        end

        repeat (4) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
